// File: rtl/jtag_data_register.sv
// JTAG test data register: WIDTH-bit capture/shift/update path with a
// shadow parallel register, 1-bit bypass mode and shift-length checking.
module jtag_data_register #(
    parameter  int               WIDTH        = 8,
    parameter  logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter  bit               LENGTH_CHECK = 1'b1,
    localparam int               CNT_W        = $clog2(WIDTH + 2)
) (
    input  logic             ClockDR,
    input  logic             TRST_n,
    input  logic             scan_in,
    input  logic             CaptureDR,
    input  logic             ShiftDR,
    input  logic             UpdateDR,
    input  logic             Select,
    input  logic             BypassMode,
    input  logic [WIDTH-1:0] capture_data,
    output logic             scan_out,
    output logic [WIDTH-1:0] parallel_out,
    output logic             update_strobe,
    output logic             length_error,
    output logic [CNT_W-1:0] shift_count
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    logic [WIDTH-1:0] r_shift;
    logic             r_bypass;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_parallel;
    logic             r_upd;
    logic             r_err;

    logic             w_normal;
    logic             w_bypass;
    logic             w_do_upd;
    logic             w_len_ok;

    assign w_normal = Select & ~BypassMode;
    assign w_bypass = Select &  BypassMode;
    assign w_do_upd = w_normal & ~CaptureDR & ~ShiftDR & UpdateDR;
    assign w_len_ok = !LENGTH_CHECK || (r_count == CNT_FULL);

    // Shift path and shifted-bit counter
    always_ff @(posedge ClockDR or negedge TRST_n) begin
        if (!TRST_n) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_normal) begin
            if (CaptureDR) begin
                r_shift <= capture_data;
                r_count <= '0;
            end else if (ShiftDR) begin
                r_shift <= {scan_in, r_shift[WIDTH-1:1]};
                if (r_count < CNT_SAT) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    // Bypass flop loads only during shift; capture or idle clears it
    always_ff @(posedge ClockDR or negedge TRST_n) begin
        if (!TRST_n) begin
            r_bypass <= 1'b0;
        end else if (w_bypass) begin
            r_bypass <= scan_in & ShiftDR;
        end else if (w_normal) begin
            r_bypass <= 1'b0;
        end
    end

    always_ff @(posedge ClockDR or negedge TRST_n) begin
        if (!TRST_n) begin
            r_parallel <= RESET_VALUE;
            r_upd      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_upd <= w_do_upd &  w_len_ok;
            r_err <= w_do_upd & ~w_len_ok;
            if (w_do_upd && w_len_ok) begin
                r_parallel <= r_shift;
            end
        end
    end

    assign scan_out      = BypassMode ? r_bypass : r_shift[0];
    assign parallel_out  = r_parallel;
    assign update_strobe = r_upd;
    assign length_error  = r_err;
    assign shift_count   = r_count;

endmodule

// File: doc/jtag_data_register.md
# jtag_data_register

Parametrised JTAG test data register (TDR), the general-purpose successor to the single-bit bypass stage. It implements Capture/Shift/Update on a WIDTH-bit shift path with a shadow parallel-output register, a built-in 1-bit bypass mode, and a shifted-bit counter that can reject updates of the wrong length. It sits between the TAP controller/instruction decoder (which drive CaptureDR/ShiftDR/UpdateDR/Select) and on-chip logic consuming or supplying parallel test data.

## Interface
- WIDTH, 8: shift/parallel register width, ≥2
- RESET_VALUE, 0: reset value of parallel_out (WIDTH bits)
- LENGTH_CHECK, 1: 1 = commit update only if exactly WIDTH bits were shifted since the last capture; 0 = always commit
- CNT_W, $clog2(WIDTH+2): shift_count width (derived, not overridden)

- ClockDR  in  1  sole clock, all state on rising edge
- TRST_n  in  1  asynchronous active-low reset
- scan_in  in  1  serial data in (TDI path)
- CaptureDR  in  1  capture enable
- ShiftDR  in  1  shift enable
- UpdateDR  in  1  update enable (synchronous enable, not a clock)
- Select  in  1  register selected by instruction decoder
- BypassMode  in  1  1 = behave as 1-bit bypass register
- capture_data  in  WIDTH  parallel value loaded on capture
- scan_out  out  1  serial data out; direct from flops, no combinational path from scan_in
- parallel_out  out  WIDTH  committed shadow register
- update_strobe  out  1  one-cycle pulse: update committed
- length_error  out  1  one-cycle pulse: update rejected
- shift_count  out  CNT_W  bits shifted since last capture, saturating

## Operation
- State: shift_reg[WIDTH-1:0], bypass_q, count, parallel_out, update_strobe, length_error.
- Reset (TRST_n=0, asynchronous): shift_reg=0, bypass_q=0, count=0, parallel_out=RESET_VALUE, update_strobe=0, length_error=0, so scan_out=0. Held in reset regardless of ClockDR.
- Select=0: shift_reg, bypass_q, count and parallel_out hold; strobes go 0.
- Select=1, BypassMode=0, per edge, priority Capture > Shift > Update:
  - CaptureDR: shift_reg←capture_data; count←0.
  - else ShiftDR: shift_reg←{scan_in, shift_reg[WIDTH-1:1]} (LSB out first, enters at MSB); count←min(count+1, WIDTH+1).
  - else UpdateDR: if LENGTH_CHECK=0 or count==WIDTH: parallel_out←shift_reg, update_strobe←1; else length_error←1, parallel_out holds. count holds.
  - bypass_q←0.
- Select=1, BypassMode=1: bypass_q←scan_in & ShiftDR (capture or idle loads 0). shift_reg, count and parallel_out hold. UpdateDR has no effect and raises no strobe.
- scan_out = BypassMode ? bypass_q : shift_reg[0]. The mux follows BypassMode immediately, with no clock.
- update_strobe/length_error: 0 on any edge not committing/rejecting an update.
- Simultaneous CaptureDR+ShiftDR+UpdateDR: capture only; no strobe.
- count saturates at WIDTH+1. Overshifting by any amount is therefore detected and never wraps to WIDTH.

## Timing
- Capture→scan_out: the first bit (capture_data[0]) is visible in the cycle after the capture edge. Each subsequent shift edge presents the next bit.
- Serial latency in→out: WIDTH shift edges (normal mode), 1 shift edge (bypass mode).
- Update: parallel_out and update_strobe/length_error change at the same edge as the sampled UpdateDR. The strobe is high for exactly one cycle.
- Back-to-back UpdateDR cycles: each commits again (same data) and each pulses update_strobe.
- Reset mid-shift: takes effect without a clock edge. The partial shift is lost and parallel_out returns to RESET_VALUE.

## Test plan
- Reset: WIDTH=8, RESET_VALUE=8'hA5; pulse TRST_n with ClockDR stopped -> parallel_out=8'hA5, scan_out=0, shift_count=0, both strobes 0.
- Full cycle: capture 8'h3C, then 8 shifts with scan_in bits of 8'hC3 LSB first, then UpdateDR -> scan_out sequence 0,0,1,1,1,1,0,0 starting after capture, shift_count=8, parallel_out=8'hC3, update_strobe high exactly one cycle.
- Length check: LENGTH_CHECK=1; capture, 7 shifts, UpdateDR -> length_error one-cycle pulse, parallel_out unchanged. Repeat with 12 shifts -> shift_count=9 (saturated), rejected. With LENGTH_CHECK=0 and 7 shifts -> commit.
- Bypass: BypassMode=1; shift scan_in 1,0,1,1 -> scan_out 1,0,1,1 delayed one edge; a CaptureDR edge -> scan_out=0; UpdateDR -> no strobe, parallel_out unchanged, shift_reg preserved when BypassMode returns to 0.
- Priority/select: CaptureDR+ShiftDR together -> capture only, count=0. With Select=0, toggle all controls -> no state change, no strobes.
- Async reset mid-shift: after 4 of 8 shifts, drop TRST_n between edges -> outputs reset immediately. After release, a fresh capture/shift/update works normally.
